// File: rtl/dma_addr_sequencer_pkg.sv
// Shared types and constants for the Slipstream DMA address sequencer.
//   dma_state_t : sequencer FSM state encoding
//   STEP_BYTE   : address step for byte transfers
//   STEP_WORD   : address step for word transfers
package slipstream_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dma_state_t;

  localparam logic [1:0] STEP_BYTE = 2'd1;
  localparam logic [1:0] STEP_WORD = 2'd2;

endpackage

// File: rtl/dma_addr_sequencer_if.sv
// Address handshake between the sequencer and the bus-request stage.
//   Addr      : current transfer address
//   AddrValid : Addr is a live transfer address
//   Remaining : addresses still to issue, including the current one
//   Take      : consumer accepts the current Addr
interface dma_addr_sequencer_if #(
  parameter int AW = 20,
  parameter int CW = 16
);
  logic [AW-1:0] Addr;
  logic          AddrValid;
  logic [CW-1:0] Remaining;
  logic          Take;

  modport master (output Addr, output AddrValid, output Remaining, input Take);
  modport slave  (input Addr, input AddrValid, input Remaining, output Take);
endinterface

// File: rtl/dma_addr_sequencer_incr.sv
// Ripple incrementer built from HALFADD cells.
//   HALFADD : single half-adder cell (A, B -> S, C)
//   m_INCR  : W-bit incrementer, A + CI -> Q with carry-out CO
module HALFADD (
  input  logic A,
  input  logic B,
  output logic S,
  output logic C
);
  assign S = A ^ B;
  assign C = A & B;
endmodule

module m_INCR #(
  parameter int W = 20
) (
  input  logic [W-1:0] A,
  input  logic         CI,
  output logic [W-1:0] Q,
  output logic         CO
);
  logic [W:0] carry;

  assign carry[0] = CI;

  for (genvar i = 0; i < W; i++) begin : g_chain
    HALFADD u_ha (
      .A(A[i]),
      .B(carry[i]),
      .S(Q[i]),
      .C(carry[i+1])
    );
  end

  assign CO = carry[W];
endmodule

// File: rtl/dma_addr_sequencer.sv
// Sequential bus-address generator for block transfers.
//   MasterClock, Reset : clock and synchronous active-high reset
//   Load, StartAddr, Count, Word : shadow-register preload
//   Go, Abort          : start / terminate a transfer
//   bus                : Addr/AddrValid/Remaining out, Take in
//   Busy, Done         : RUN indicator and completion pulse
//
// state | meaning
// IDLE  | no transfer; shadow regs writable; Go starts a transfer
// RUN   | Addr live; each Take advances Addr and decrements Remaining
// DONE  | one-cycle completion pulse; Go ignored, Load accepted
module dma_addr_sequencer
  import slipstream_dma_pkg::*;
#(
  parameter int AW = 20,
  parameter int CW = 16
) (
  input  logic          MasterClock,
  input  logic          Reset,
  input  logic          Load,
  input  logic [AW-1:0] StartAddr,
  input  logic [CW-1:0] Count,
  input  logic          Word,
  input  logic          Go,
  input  logic          Abort,
  output logic          Busy,
  output logic          Done,
  dma_addr_sequencer_if.master bus
);
  dma_state_t    state_q, state_d;
  logic [AW-1:0] start_q, start_d;
  logic [CW-1:0] count_q, count_d;
  logic          word_q, word_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          word_cur_q, word_cur_d;

  logic [AW-1:0] inc_a, inc_q, addr_next;
  logic          incr_co_unused;
  logic          load_en;

  // For word steps bit 0 is forced high so the carry-in ripples straight
  // into bit 1; the original bit 0 is restored afterwards.
  assign inc_a = {addr_q[AW-1:1], addr_q[0] | word_cur_q};

  m_INCR #(.W(AW)) u_incr (
    .A (inc_a),
    .CI(1'b1),
    .Q (inc_q),
    .CO(incr_co_unused)
  );

  assign addr_next = word_cur_q ? {inc_q[AW-1:1], addr_q[0]} : inc_q;
  assign load_en   = Load && (state_q != RUN);

  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      state_q    <= IDLE;
      start_q    <= '0;
      count_q    <= '0;
      word_q     <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      word_cur_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      count_q    <= count_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      word_cur_q <= word_cur_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    count_d    = count_q;
    word_d     = word_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    word_cur_d = word_cur_q;

    if (load_en) begin
      start_d = StartAddr;
      count_d = Count;
      word_d  = Word;
    end

    unique case (state_q)
      IDLE: begin
        // start_d/count_d/word_d already reflect a same-cycle Load.
        if (Go) begin
          state_d    = RUN;
          addr_d     = start_d;
          rem_d      = count_d;
          word_cur_d = word_d;
        end
      end
      RUN: begin
        if (Abort) begin
          state_d = IDLE;
        end else if (bus.Take) begin
          addr_d = addr_next;
          rem_d  = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.Addr      = addr_q;
  assign bus.Remaining = rem_q;
  assign bus.AddrValid = (state_q == RUN);
  assign Busy          = (state_q == RUN);
  assign Done          = (state_q == DONE);
endmodule
